matrix_rx: RTL and testbench
============================

MATRIX_RX -- requirements
Module: matrix_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth (range 2..4).
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port serial_clk  input  1  matrix shift clock, asynchronous to clk.
REQ-005 SHALL have port serial_data  input  1  matrix shift data, sampled on serial_clk rise.
REQ-006 SHALL have port rclk  input  1  storage-latch strobe, active on rising edge.
REQ-007 SHALL have port clear  input  1  active-low shift-register clear.
REQ-008 SHALL have port row_sel  output  4  row index of last valid latch.
REQ-009 SHALL have port col_on  output  16  lit columns of last valid latch; bit c = column c.
REQ-010 SHALL have port frame_done  output  1  one-clk pulse when a captured frame is published.
REQ-011 SHALL have port rd_row  input  4  display-buffer read row.
REQ-012 SHALL have port rd_data  output  32  intensities of rd_row; bits [2c+1:2c] = column c.
REQ-013 SHALL have port err_cnt  output  8  saturating count of protocol errors.

Function
REQ-014 SHALL pass serial_clk, serial_data, rclk, clear through SYNC_STAGES flops, then detect rising edges of serial_clk and rclk with one further flop.
REQ-015 SHALL, on each serial_clk rise while synchronized clear is high, shift sr <= {sr[30:0], serial_data}.
REQ-016 SHALL hold sr at 0 and ignore shifts while synchronized clear is low.
REQ-017 SHALL map first-shifted bit k (0..15) to anode row k: anode = sr[31:16], row k at sr[31-k]; cathode bit for column c at sr[15-c], lit when 0.
REQ-018 SHALL, on an rclk rise coinciding with a serial_clk rise, latch the pre-shift sr value.
REQ-019 SHALL treat a latch as valid only when anode is exactly one-hot; otherwise increment err_cnt and make no other change.
REQ-020 SHALL, on a valid latch, update row_sel and col_on (= ~cathode) one clk after the rclk edge detect.
REQ-021 SHALL keep a 6-bit latch counter lc; expected row = lc[3:0]; density pass = lc[5:4].
REQ-022 SHALL, on a valid latch with row == lc[3:0], increment each lit pixel of that row in the working buffer, saturating at 3, then increment lc.
REQ-023 SHALL, on a valid latch with row != lc[3:0], increment err_cnt, clear the working buffer, set lc to {2'b00, row+1}, and accumulate nothing.
REQ-024 SHALL, when lc wraps 63 -> 0, copy the updated working buffer to the display buffer, clear the working buffer, and pulse frame_done for one clk in the same cycle as the copy.
REQ-025 SHALL register rd_data from the display buffer with one-clk latency from rd_row.
REQ-026 SHALL saturate err_cnt at 255.
REQ-027 SHALL make pixel intensity equal the number of density passes (0..3) in which the pixel was lit.

Reset
REQ-028 SHALL, while rst_n is low, clear synchronizers, sr, lc, working and display buffers, row_sel, col_on, frame_done, rd_data, and err_cnt to 0.
REQ-029 SHALL, on rst_n low mid-frame, discard the partial frame; the first frame_done after release requires 64 fresh in-order latches.

Verification
REQ-030 SHALL pass: 32 bits with anode one-hot row 5, cathode 0 at column 2 only, then rclk rise -> row_sel=5, col_on=16'h0004, err_cnt=0.
REQ-031 SHALL pass: anode 16'h0000 or 16'h0003 latched -> err_cnt +1; row_sel, col_on, and lc unchanged.
REQ-032 SHALL pass: 64 in-order latches encoding pixel (0,2)=3, (1,9)=1, all others 0, generated by the lit-when-value>pass rule -> frame_done once; rd_row=0 gives rd_data[5:4]=3; rd_row=1 gives rd_data[19:18]=1; all other fields 0.
REQ-033 SHALL pass: expected row 4 but row 7 received -> err_cnt +1, working buffer cleared, next accepted row is 8.
REQ-034 SHALL pass: clear low for 10 serial_clk rises, then rclk -> anode 0, counted as error; after clear high, shifting resumes normally.
REQ-035 SHALL pass: rclk rise coinciding with serial_clk rise -> captured word equals pre-shift sr; 300 invalid latches -> err_cnt holds 255.

Source files
------------

// File: rtl/matrix_rx.sv
// matrix_rx: receives a serially shifted LED-matrix word (anode row + cathode
// columns), latches it on an rclk strobe, tracks the current row/columns, and
// integrates four density passes of 16 rows into a 2-bit-per-pixel display
// buffer that is published once per complete 64-latch frame.
module matrix_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        serial_clk,
    input  logic        serial_data,
    input  logic        rclk,
    input  logic        clear,
    output logic [3:0]  row_sel,
    output logic [15:0] col_on,
    output logic        frame_done,
    input  logic [3:0]  rd_row,
    output logic [31:0] rd_data,
    output logic [7:0]  err_cnt
);

    // Synchronizer chains; all four inputs use the same depth so that
    // serial_data stays aligned with the serial_clk edge that samples it.
    logic [SYNC_STAGES-1:0] r_sync_sclk;
    logic [SYNC_STAGES-1:0] r_sync_sdat;
    logic [SYNC_STAGES-1:0] r_sync_rclk;
    logic [SYNC_STAGES-1:0] r_sync_clr;
    logic                   r_sclk_d;
    logic                   r_rclk_d;

    logic w_sclk_s;
    logic w_sdat_s;
    logic w_rclk_s;
    logic w_clr_s;
    logic w_sclk_rise;
    logic w_rclk_rise;

    // Shift register and the word captured by the storage latch.
    logic [31:0] r_sr;
    logic [31:0] r_lat_word;
    logic        r_lat_vld;

    // Decoded view of the captured word.
    logic [15:0] w_anode;
    logic        w_onehot;
    logic [3:0]  w_row;
    logic [15:0] w_cols;
    logic        w_row_ok;
    logic        w_accept;
    logic        w_resync;
    logic        w_err_inc;
    logic [31:0] w_old_row;
    logic [31:0] w_new_row;

    // Frame accumulation state.
    logic [5:0]  r_lc;
    logic [31:0] r_work [16];
    logic [31:0] r_disp [16];
    logic        r_frame_done;
    logic [3:0]  r_row_sel;
    logic [15:0] r_col_on;
    logic [7:0]  r_err_cnt;
    logic [31:0] r_rd_data;

    assign w_sclk_s    = r_sync_sclk[SYNC_STAGES-1];
    assign w_sdat_s    = r_sync_sdat[SYNC_STAGES-1];
    assign w_rclk_s    = r_sync_rclk[SYNC_STAGES-1];
    assign w_clr_s     = r_sync_clr[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_rclk_rise = w_rclk_s & ~r_rclk_d;

    // Bring the asynchronous matrix signals into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_sclk <= '0;
            r_sync_sdat <= '0;
            r_sync_rclk <= '0;
            r_sync_clr  <= '0;
            r_sclk_d    <= 1'b0;
            r_rclk_d    <= 1'b0;
        end else begin
            r_sync_sclk <= {r_sync_sclk[SYNC_STAGES-2:0], serial_clk};
            r_sync_sdat <= {r_sync_sdat[SYNC_STAGES-2:0], serial_data};
            r_sync_rclk <= {r_sync_rclk[SYNC_STAGES-2:0], rclk};
            r_sync_clr  <= {r_sync_clr[SYNC_STAGES-2:0], clear};
            r_sclk_d    <= w_sclk_s;
            r_rclk_d    <= w_rclk_s;
        end
    end

    // Shift register: held at zero while clear is low, else shifts on serial_clk rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= '0;
        end else if (!w_clr_s) begin
            r_sr <= '0;
        end else if (w_sclk_rise) begin
            r_sr <= {r_sr[30:0], w_sdat_s};
        end
    end

    // Storage latch: r_sr still holds the pre-shift value on a coincident edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_word <= '0;
            r_lat_vld  <= 1'b0;
        end else begin
            r_lat_vld <= w_rclk_rise;
            if (w_rclk_rise) begin
                r_lat_word <= r_sr;
            end
        end
    end

    assign w_anode  = r_lat_word[31:16];
    assign w_onehot = (w_anode != 16'd0) && ((w_anode & (w_anode - 16'd1)) == 16'd0);
    assign w_row_ok = (w_row == r_lc[3:0]);
    assign w_accept  = r_lat_vld & w_onehot & w_row_ok;
    assign w_resync  = r_lat_vld & w_onehot & ~w_row_ok;
    assign w_err_inc = r_lat_vld & (~w_onehot | ~w_row_ok);

    // Decode row index (first-shifted bit k is row k) and active-low cathodes.
    always_comb begin
        w_row  = 4'd0;
        w_cols = '0;
        for (int k = 0; k < 16; k++) begin
            if (r_lat_word[31-k]) begin
                w_row = 4'(k);
            end
            w_cols[k] = ~r_lat_word[15-k];
        end
    end

    // Saturating per-pixel increment of the addressed working-buffer row.
    always_comb begin
        w_old_row = r_work[w_row];
        w_new_row = w_old_row;
        for (int c = 0; c < 16; c++) begin
            if (w_cols[c] && (w_old_row[2*c +: 2] != 2'd3)) begin
                w_new_row[2*c +: 2] = w_old_row[2*c +: 2] + 2'd1;
            end
        end
    end

    // Visible row/column status follows every one-hot latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_sel <= '0;
            r_col_on  <= '0;
        end else if (r_lat_vld && w_onehot) begin
            r_row_sel <= w_row;
            r_col_on  <= w_cols;
        end
    end

    // Frame accumulation, resync on out-of-order rows, publish on lc wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lc         <= '0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_work[i] <= '0;
                r_disp[i] <= '0;
            end
        end else begin
            r_frame_done <= 1'b0;
            if (w_accept) begin
                r_lc <= r_lc + 6'd1;
                if (r_lc == 6'd63) begin
                    for (int i = 0; i < 16; i++) begin
                        r_disp[i] <= (4'(i) == w_row) ? w_new_row : r_work[i];
                        r_work[i] <= '0;
                    end
                    r_frame_done <= 1'b1;
                end else begin
                    r_work[w_row] <= w_new_row;
                end
            end else if (w_resync) begin
                for (int i = 0; i < 16; i++) begin
                    r_work[i] <= '0;
                end
                r_lc <= {2'b00, w_row + 4'd1};
            end
        end
    end

    // Saturating protocol error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_err_inc && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    // Registered display-buffer read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_disp[rd_row];
        end
    end

    assign row_sel    = r_row_sel;
    assign col_on     = r_col_on;
    assign frame_done = r_frame_done;
    assign rd_data    = r_rd_data;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_matrix_rx.sv
// tb_matrix_rx: directed-plus-random bench for matrix_rx with a pixel-level
// reference model (shift register contents, latch counter, intensity arrays).
module tb_matrix_rx;

  logic        clk;
  logic        rst_n;
  logic        serial_clk;
  logic        serial_data;
  logic        rclk;
  logic        clear;
  logic [3:0]  row_sel;
  logic [15:0] col_on;
  logic        frame_done;
  logic [3:0]  rd_row;
  logic [31:0] rd_data;
  logic [7:0]  err_cnt;

  matrix_rx #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .serial_clk  (serial_clk),
    .serial_data (serial_data),
    .rclk        (rclk),
    .clear       (clear),
    .row_sel     (row_sel),
    .col_on      (col_on),
    .frame_done  (frame_done),
    .rd_row      (rd_row),
    .rd_data     (rd_data),
    .err_cnt     (err_cnt)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks;
  int failures;
  int fd_cnt;

  // Cycles with frame_done high; a stuck or stretched pulse over-counts.
  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
  end

  // ---------------- reference model ----------------
  logic [31:0] m_sr;
  int          m_lc;
  int          m_err;
  int          m_row_sel;
  logic [15:0] m_col_on;
  int          m_frames;
  int          m_work [16][16];
  int          m_disp [16][16];
  int          val    [16][16];

  task automatic model_reset();
    m_sr = '0; m_lc = 0; m_err = 0; m_row_sel = 0; m_col_on = '0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        m_work[r][c] = 0;
        m_disp[r][c] = 0;
      end
  endtask

  task automatic model_err();
    if (m_err < 255) m_err++;
  endtask

  task automatic model_latch(input logic [31:0] w);
    int ones;
    int row;
    ones = 0;
    row = 0;
    for (int k = 0; k < 16; k++)
      if (w[31-k]) begin
        ones++;
        row = k;
      end
    if (ones != 1) begin
      model_err();
    end else begin
      m_row_sel = row;
      for (int c = 0; c < 16; c++) m_col_on[c] = ~w[15-c];
      if (row == m_lc % 16) begin
        for (int c = 0; c < 16; c++)
          if (m_col_on[c] && m_work[row][c] < 3) m_work[row][c]++;
        m_lc++;
        if (m_lc == 64) begin
          m_lc = 0;
          m_frames++;
          for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
              m_disp[r][c] = m_work[r][c];
              m_work[r][c] = 0;
            end
        end
      end else begin
        model_err();
        for (int r = 0; r < 16; r++)
          for (int c = 0; c < 16; c++) m_work[r][c] = 0;
        m_lc = (row + 1) % 16;
      end
    end
  endtask

  function automatic logic [31:0] mk_word(input int row, input logic [15:0] lit);
    logic [31:0] w;
    w = '0;
    w[31-row] = 1'b1;
    for (int c = 0; c < 16; c++) w[15-c] = ~lit[c];
    return w;
  endfunction

  function automatic logic [31:0] pack_row(input int r);
    logic [31:0] d;
    d = '0;
    for (int c = 0; c < 16; c++) d[2*c +: 2] = 2'(m_disp[r][c]);
    return d;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "/row_sel"}, 32'(row_sel), 32'(m_row_sel));
    check({tag, "/col_on"}, 32'(col_on), 32'(m_col_on));
    check({tag, "/err_cnt"}, 32'(err_cnt), 32'(m_err));
    check({tag, "/frames"}, 32'(fd_cnt), 32'(m_frames));
  endtask

  task automatic check_disp(input string tag);
    for (int r = 0; r < 16; r++) begin
      rd_row = 4'(r);
      repeat (2) @(negedge clk);
      check($sformatf("%s/rd_row%0d", tag, r), rd_data, pack_row(r));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic sclk_pulse(input logic d);
    serial_data = d;
    repeat (2) @(negedge clk);
    serial_clk = 1'b1;
    repeat (3) @(negedge clk);
    serial_clk = 1'b0;
    repeat (2) @(negedge clk);
    m_sr = clear ? {m_sr[30:0], d} : 32'd0;
  endtask

  task automatic shift_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) sclk_pulse(w[i]);
  endtask

  task automatic pulse_rclk();
    rclk = 1'b1;
    repeat (3) @(negedge clk);
    rclk = 1'b0;
    repeat (4) @(negedge clk);
    model_latch(m_sr);
  endtask

  task automatic send_latch(input string tag, input logic [31:0] w);
    shift_word(w);
    pulse_rclk();
    check_outputs(tag);
  endtask

  task automatic send_row(input string tag, input int row, input logic [15:0] lit);
    send_latch(tag, mk_word(row, lit));
  endtask

  task automatic run_frame(input string tag);
    logic [15:0] lit;
    for (int p = 0; p < 4; p++)
      for (int r = 0; r < 16; r++) begin
        for (int c = 0; c < 16; c++) lit[c] = (val[r][c] > p);
        send_row(tag, r, lit);
      end
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    serial_clk = 1'b0;
    rclk = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    check({tag, "/row_sel"}, 32'(row_sel), 32'd0);
    check({tag, "/col_on"}, 32'(col_on), 32'd0);
    check({tag, "/frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "/err_cnt"}, 32'(err_cnt), 32'd0);
    check({tag, "/rd_data"}, rd_data, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] w;
    logic        d;
    int          row;
    checks = 0; failures = 0; fd_cnt = 0; m_frames = 0;
    serial_clk = 1'b0; serial_data = 1'b0; rclk = 1'b0; clear = 1'b1; rd_row = 4'd0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    apply_reset("reset");

    // In-order rows 0..4 with random columns, then row 5 with only column 2 lit.
    for (int r = 0; r < 5; r++) send_row("pre_rows", r, 16'($urandom_range(0, 65535)));
    send_row("row5", 5, 16'h0004);
    check("row5/row_sel_exact", 32'(row_sel), 32'd5);
    check("row5/col_on_exact", 32'(col_on), 32'h0004);
    check("row5/err_zero", 32'(err_cnt), 32'd0);

    // Invalid anodes: zero and two-hot; status must hold.
    send_latch("anode0", {16'h0000, 16'($urandom_range(0, 65535))});
    send_latch("anode3", {16'h0003, 16'($urandom_range(0, 65535))});
    check("anode3/row_sel_hold", 32'(row_sel), 32'd5);
    check("anode3/col_on_hold", 32'(col_on), 32'h0004);
    send_row("row6_after_invalid", 6, 16'($urandom_range(0, 65535)));

    // Reset mid-frame, then an out-of-order row 7 where row 4 is expected.
    apply_reset("mid_reset");
    for (int r = 0; r < 4; r++) send_row("resync_pre", r, 16'($urandom_range(0, 65535)));
    send_row("row7_oos", 7, 16'($urandom_range(0, 65535)));
    send_row("row8_next", 8, 16'($urandom_range(0, 65535)));
    check("row8/err_one", 32'(err_cnt), 32'd1);

    // Row 15 out of order resyncs the latch counter to row 0.
    send_row("row15_oos", 15, 16'h0000);

    // Directed frame: pixel (0,2)=3, (1,9)=1, everything else 0.
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) val[r][c] = 0;
    val[0][2] = 3;
    val[1][9] = 1;
    run_frame("frame_dir");
    check("frame_dir/count", 32'(fd_cnt), 32'd1);
    check_disp("frame_dir");
    rd_row = 4'd0;
    repeat (2) @(negedge clk);
    w = rd_data;
    check("frame_dir/pix02", 32'(w[5:4]), 32'd3);
    rd_row = 4'd1;
    repeat (2) @(negedge clk);
    w = rd_data;
    check("frame_dir/pix19", 32'(w[19:18]), 32'd1);

    // Random-intensity frame.
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) val[r][c] = $urandom_range(0, 3);
    run_frame("frame_rand");
    check_disp("frame_rand");

    // Clear held low across 10 shifts: latched word is zero.
    clear = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) sclk_pulse(1'($urandom_range(0, 1)));
    pulse_rclk();
    check_outputs("clear_low");
    clear = 1'b1;
    repeat (4) @(negedge clk);
    send_row("after_clear", m_lc % 16, 16'($urandom_range(0, 65535)));

    // rclk coincident with serial_clk: the pre-shift word is latched.
    row = m_lc % 16;
    shift_word(mk_word(row, 16'($urandom_range(0, 65535))));
    d = 1'($urandom_range(0, 1));
    serial_data = d;
    repeat (2) @(negedge clk);
    serial_clk = 1'b1;
    rclk = 1'b1;
    repeat (3) @(negedge clk);
    serial_clk = 1'b0;
    rclk = 1'b0;
    repeat (4) @(negedge clk);
    model_latch(m_sr);
    m_sr = {m_sr[30:0], d};
    check_outputs("coincident");
    check("coincident/row_sel_exact", 32'(row_sel), 32'(row));

    // Flood with invalid latches: counter saturates.
    shift_word(32'd0);
    for (int i = 0; i < 300; i++) begin
      pulse_rclk();
      if (i == 100) check_outputs("flood_mid");
    end
    check_outputs("flood_end");
    check("flood/err_sat", 32'(err_cnt), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
